// File: rtl/ps2_keyboard_frontend_if.sv
// Front-panel output bundle of the PS/2 keyboard block: received byte, strobe,
// ASCII translation, two seven-segment digits and the divided slow clock.
interface ps2_keyboard_frontend_if;
  logic [7:0] key_data;
  logic       key_pressed;
  logic [7:0] last_code;
  logic [7:0] ascii;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic       clk_1hz;

  modport master (
    output key_data, key_pressed, last_code, ascii, hex0, hex1, clk_1hz
  );

  modport slave (
    input key_data, key_pressed, last_code, ascii, hex0, hex1, clk_1hz
  );
endinterface

// File: rtl/ps2_keyboard_frontend.sv
// PS/2 keyboard receiver with scan-code to ASCII translation, seven-segment
// display of the last code and an independent square-wave clock divider.
module ps2_keyboard_frontend #(
  parameter int CLK_FREQ       = 50000000,
  parameter int OUT_FREQ       = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                           clk,
  input  logic                           RESETN,
  inout  wire                            ps2_clk,
  inout  wire                            ps2_dat,
  ps2_keyboard_frontend_if.master        o_kbd
);

  localparam int HALF  = CLK_FREQ / (2 * OUT_FREQ);
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {ST_IDLE, ST_RECV} state_t;

  function automatic logic [8:0] scan_to_ascii(input logic [7:0] code);
    case (code)
      8'h1C: return {1'b1, "a"};
      8'h32: return {1'b1, "b"};
      8'h21: return {1'b1, "c"};
      8'h23: return {1'b1, "d"};
      8'h24: return {1'b1, "e"};
      8'h2B: return {1'b1, "f"};
      8'h34: return {1'b1, "g"};
      8'h33: return {1'b1, "h"};
      8'h43: return {1'b1, "i"};
      8'h3B: return {1'b1, "j"};
      8'h42: return {1'b1, "k"};
      8'h4B: return {1'b1, "l"};
      8'h3A: return {1'b1, "m"};
      8'h31: return {1'b1, "n"};
      8'h44: return {1'b1, "o"};
      8'h4D: return {1'b1, "p"};
      8'h15: return {1'b1, "q"};
      8'h2D: return {1'b1, "r"};
      8'h1B: return {1'b1, "s"};
      8'h2C: return {1'b1, "t"};
      8'h3C: return {1'b1, "u"};
      8'h2A: return {1'b1, "v"};
      8'h1D: return {1'b1, "w"};
      8'h22: return {1'b1, "x"};
      8'h35: return {1'b1, "y"};
      8'h1A: return {1'b1, "z"};
      8'h29: return {1'b1, 8'd32};
      8'h66: return {1'b1, 8'd127};
      default: return 9'h000;
    endcase
  endfunction

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  logic [1:0]      r_ps2c_sync, r_ps2d_sync;
  logic            r_ps2c_prev;
  state_t          r_state, w_state_nxt;
  logic [3:0]      r_bit_cnt;
  logic [8:0]      r_shift;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_key_data, r_last_code, r_ascii;
  logic            r_key_pressed;
  logic [CNT_W-1:0] r_div_cnt;
  logic            r_clk_1hz;
  logic            w_fall, w_dat, w_accept, w_timeout;
  logic [8:0]      w_ascii;

  // Lines are only ever sampled; the keyboard owns both open-collector wires.
  always_ff @(posedge clk or posedge RESETN) begin
    if (RESETN) begin
      r_ps2c_sync <= 2'b11;
      r_ps2d_sync <= 2'b11;
      r_ps2c_prev <= 1'b1;
    end else begin
      r_ps2c_sync <= {r_ps2c_sync[0], ps2_clk};
      r_ps2d_sync <= {r_ps2d_sync[0], ps2_dat};
      r_ps2c_prev <= r_ps2c_sync[1];
    end
  end

  assign w_fall    = r_ps2c_prev & ~r_ps2c_sync[1];
  assign w_dat     = r_ps2d_sync[1];
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_ascii   = scan_to_ascii(r_shift[7:0]);

  always_ff @(posedge clk or posedge RESETN) begin
    if (RESETN) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Stop bit arrives on the tenth edge after start; r_shift then holds data+parity.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_fall && !w_dat) w_state_nxt = ST_RECV;
      ST_RECV: begin
        if (w_fall) begin
          if (r_bit_cnt == 4'd9) begin
            w_state_nxt = ST_IDLE;
            w_accept    = w_dat & (^r_shift);
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RESETN) begin
    if (RESETN) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_to_cnt  <= '0;
    end else if (r_state == ST_RECV) begin
      if (w_fall) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
        r_shift   <= {w_dat, r_shift[8:1]};
        r_to_cnt  <= '0;
      end else begin
        r_to_cnt  <= r_to_cnt + 1'b1;
      end
    end else begin
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
    end
  end

  always_ff @(posedge clk or posedge RESETN) begin
    if (RESETN) begin
      r_key_data    <= '0;
      r_last_code   <= '0;
      r_ascii       <= '0;
      r_key_pressed <= 1'b0;
    end else begin
      r_key_pressed <= w_accept;
      if (w_accept) begin
        r_key_data  <= r_shift[7:0];
        r_last_code <= r_shift[7:0];
        if (w_ascii[8]) r_ascii <= w_ascii[7:0];
      end
    end
  end

  // Free-running divider, independent of the keyboard path.
  always_ff @(posedge clk or posedge RESETN) begin
    if (RESETN) begin
      r_div_cnt <= '0;
      r_clk_1hz <= 1'b0;
    end else if (r_div_cnt == CNT_W'(HALF - 1)) begin
      r_div_cnt <= '0;
      r_clk_1hz <= ~r_clk_1hz;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign o_kbd.key_data    = r_key_data;
  assign o_kbd.key_pressed = r_key_pressed;
  assign o_kbd.last_code   = r_last_code;
  assign o_kbd.ascii       = r_ascii;
  assign o_kbd.hex0        = hex_to_seg(r_last_code[3:0]);
  assign o_kbd.hex1        = hex_to_seg(r_last_code[7:4]);
  assign o_kbd.clk_1hz     = r_clk_1hz;

endmodule

// File: tb/tb_ps2_keyboard_frontend.sv
// Scoreboard bench for ps2_keyboard_frontend: directed PS/2 frames, divider timing, resets.
module tb_ps2_keyboard_frontend;

  localparam int TO   = 200;
  localparam int PS2H = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic RESETN;
  logic r_ps2c = 1'b1;
  logic r_ps2d = 1'b1;
  wire  ps2_clk;
  wire  ps2_dat;
  assign ps2_clk = r_ps2c;
  assign ps2_dat = r_ps2d;

  ps2_keyboard_frontend_if kbd ();

  ps2_keyboard_frontend #(
    .CLK_FREQ      (8),
    .OUT_FREQ      (1),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk    (clk),
    .RESETN (RESETN),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .o_kbd  (kbd)
  );

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] asc;
    logic [6:0] h1;
    logic [6:0] h0;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame bits: start, 8 data LSB first, odd parity (optionally corrupted), stop.
  task automatic send(input logic [7:0] b, input bit flip, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      r_ps2d = f[i];
      repeat (PS2H) @(posedge clk);
      r_ps2c = 1'b0;
      repeat (PS2H) @(posedge clk);
      r_ps2c = 1'b1;
    end
    repeat (PS2H) @(posedge clk);
    r_ps2d = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!RESETN && kbd.key_pressed) begin
      exp_t e;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got key_data %0h expected no strobe", kbd.key_data);
      end else begin
        e = q.pop_front();
        chk("key_data",  kbd.key_data,  e.code);
        chk("last_code", kbd.last_code, e.code);
        chk("ascii",     kbd.ascii,     e.asc);
        chk("hex1",      kbd.hex1,      e.h1);
        chk("hex0",      kbd.hex0,      e.h0);
      end
    end
  end

  initial begin
    RESETN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_data",    kbd.key_data,    0);
    chk("rst_last_code",   kbd.last_code,   0);
    chk("rst_ascii",       kbd.ascii,       0);
    chk("rst_key_pressed", kbd.key_pressed, 0);
    chk("rst_hex0",        kbd.hex0,        7'h40);
    chk("rst_hex1",        kbd.hex1,        7'h40);
    chk("rst_clk_1hz",     kbd.clk_1hz,     0);

    @(negedge clk) RESETN = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk("div_run1", kbd.clk_1hz, (k / 4) % 2);
    end
    RESETN = 1'b1;
    #1;
    chk("div_async_rst", kbd.clk_1hz, 0);
    @(negedge clk) RESETN = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk("div_run2", kbd.clk_1hz, (k / 4) % 2);
    end

    q.push_back('{8'h1C, 8'd97, 7'h79, 7'h46});
    send(8'h1C, 1'b0, 11);
    repeat (50) @(posedge clk);
    q.push_back('{8'h29, 8'd32, 7'h24, 7'h10});
    send(8'h29, 1'b0, 11);
    repeat (50) @(posedge clk);
    q.push_back('{8'hF0, 8'd32, 7'h0E, 7'h40});
    send(8'hF0, 1'b0, 11);
    repeat (50) @(posedge clk);

    send(8'h1B, 1'b1, 11);
    repeat (50) @(posedge clk);
    #1;
    chk("badpar_key_data",  kbd.key_data,  8'hF0);
    chk("badpar_last_code", kbd.last_code, 8'hF0);
    chk("badpar_ascii",     kbd.ascii,     8'd32);
    chk("badpar_hex0",      kbd.hex0,      7'h40);

    send(8'h1D, 1'b0, 8);
    repeat (TO + 50) @(posedge clk);
    q.push_back('{8'h1D, 8'd119, 7'h79, 7'h21});
    send(8'h1D, 1'b0, 11);
    repeat (50) @(posedge clk);

    send(8'h5A, 1'b0, 6);
    RESETN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_key_data",  kbd.key_data,  0);
    chk("midrst_last_code", kbd.last_code, 0);
    chk("midrst_ascii",     kbd.ascii,     0);
    chk("midrst_hex1",      kbd.hex1,      7'h40);
    @(negedge clk) RESETN = 1'b0;
    repeat (10) @(posedge clk);
    q.push_back('{8'h66, 8'd127, 7'h02, 7'h02});
    send(8'h66, 1'b0, 11);
    repeat (50) @(posedge clk);

    chk("pending_strobes", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
